skid_pipe: RTL and testbench

SKID_PIPE -- requirements
Module: skid_pipe

---
 rtl/skid_pipe.sv | 52 +++++
 tb/tb_skid_pipe.sv | 116 +++++++++++
 2 files changed

// File: rtl/skid_pipe.sv
// skid_pipe: two-entry skid buffer with registered pin_ready/pout_valid and no combinational in-to-out path.
// Define SKID_PIPE_DATA_GATE_EN to force pout_data to zero whenever pout_valid is low.
module skid_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  pin_valid,
  input  logic [DATA_WIDTH-1:0] pin_data,
  output logic                  pin_ready,
  output logic                  pout_valid,
  output logic [DATA_WIDTH-1:0] pout_data,
  input  logic                  pout_ready,
  output logic [1:0]            occ
);
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
  state_t state, nxt;
  logic [DATA_WIDTH-1:0] main_q, skid_q;
  logic in_fire, out_fire;
  always_comb begin
    in_fire = pin_valid & pin_ready;
    out_fire = pout_valid & pout_ready;
    nxt = state == EMPTY ? (in_fire ? BUSY : EMPTY) :
          state == BUSY  ? (in_fire & ~out_fire ? FULL : ~in_fire & out_fire ? EMPTY : BUSY) :
                           (out_fire ? BUSY : FULL);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= EMPTY;
      pout_valid <= 1'b0;
      pin_ready <= 1'b0;
      occ <= 2'd0;
    end else begin
      state <= nxt;
      pout_valid <= nxt != EMPTY;
      pin_ready <= nxt != FULL;
      occ <= nxt == FULL ? 2'd2 : nxt == BUSY ? 2'd1 : 2'd0;
    end
  end
  // Payload registers carry no reset; stale contents are masked by the state flops.
  always_ff @(posedge clk) begin
    if ((state == EMPTY && in_fire) || (state == BUSY && in_fire && out_fire) || (state == FULL && out_fire))
      main_q <= state == FULL ? skid_q : pin_data;
    if (state == BUSY && in_fire && !out_fire)
      skid_q <= pin_data;
  end
`ifdef SKID_PIPE_DATA_GATE_EN
  assign pout_data = main_q & {DATA_WIDTH{pout_valid}};
`else
  assign pout_data = main_q;
`endif
endmodule

// File: tb/tb_skid_pipe.sv
// tb_skid_pipe: scoreboard bench for skid_pipe; a queue model predicts occupancy, handshakes and output order.
module tb_skid_pipe;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic pin_valid = 1'b0;
  logic pout_ready = 1'b0;
  logic [31:0] pin_data = '0;
  logic pin_ready, pout_valid;
  logic [31:0] pout_data;
  logic [1:0] occ;
  logic [31:0] q[$];
  logic m_rdy = 1'b0;
  logic acc;
  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  int base;
  always #5 clk = ~clk;
  skid_pipe #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .pin_valid(pin_valid), .pin_data(pin_data), .pin_ready(pin_ready),
    .pout_valid(pout_valid), .pout_data(pout_data), .pout_ready(pout_ready), .occ(occ)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Evaluate handshakes from the model mid-cycle, advance one edge, then compare the DUT to the model.
  task automatic tick();
    logic in_f, out_f;
    in_f = pin_valid & m_rdy;
    out_f = (q.size() != 0) && pout_ready;
    if (!rstn) begin
      q.delete();
      m_rdy = 1'b0;
    end else begin
      if (out_f) begin
        chk("out_word", pout_data, q[0]);
        n_out++;
        void'(q.pop_front());
      end
      if (in_f) q.push_back(pin_data);
      m_rdy = q.size() < 2;
    end
    @(negedge clk);
    chk("occ", 32'(occ), 32'(q.size()));
    chk("pin_ready", 32'(pin_ready), 32'(m_rdy));
    chk("pout_valid", 32'(pout_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("pout_data", pout_data, q[0]);
`ifdef SKID_PIPE_DATA_GATE_EN
    if (q.size() == 0) chk("gated_data", pout_data, 32'h0);
`endif
  endtask
  initial begin
    pin_valid = 1'b1;
    pin_data = 32'hDEAD0000;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    pin_valid = 1'b0;
    tick();
    base = n_out;
    pout_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      pin_valid = 1'b1;
      pin_data = 32'(i);
      tick();
    end
    pin_valid = 1'b0;
    tick();
    chk("stream_count", 32'(n_out - base), 32'd8);
    pout_ready = 1'b0;
    pin_valid = 1'b1;
    pin_data = 32'hA;
    tick();
    pin_data = 32'hB;
    tick();
    pin_data = 32'hC;
    repeat (3) tick();
    base = n_out;
    pout_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      acc = pin_valid & m_rdy;
      tick();
      if (acc) pin_valid = 1'b0;
    end
    chk("drain_count", 32'(n_out - base), 32'd3);
    pout_ready = 1'b0;
    pin_valid = 1'b1;
    pin_data = 32'hA;
    tick();
    pin_data = 32'hB;
    tick();
    pin_valid = 1'b0;
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (2) tick();
    pout_ready = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 10000; k++) begin
      pin_valid = 1'($urandom_range(0, 1));
      pout_ready = 1'($urandom_range(0, 1));
      pin_data = $urandom;
      tick();
    end
    pin_valid = 1'b0;
    pout_ready = 1'b1;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
